// File: rtl/isp1362_avalon_bridge.sv
// Avalon-MM slave that turns each 16-bit access into one timed ISP1362 CS/RD/WR bus cycle.
// Define ISP1362_BRIDGE_INT_SYNC_EN to pass the interrupt inputs through two-flop synchronizers.
module isp1362_avalon_bridge #(
    parameter int unsigned SETUP_CYC    = 1,
    parameter int unsigned STROBE_CYC   = 3,
    parameter int unsigned HOLD_CYC     = 1,
    parameter int unsigned RECOVERY_CYC = 4
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [1:0]  avs_address,
    input  logic        avs_chipselect,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [15:0] avs_writedata,
    output logic [15:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic        avs_irq,
    output logic [1:0]  oADDR,
    output logic        oCS_N,
    output logic        oRD_N,
    output logic        oWR_N,
    output logic [15:0] oDATA,
    input  logic [15:0] iDATA,
    input  logic        iINT0_N,
    input  logic        iINT1_N
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold,
        StDone,
        StRecover
    } state_e;

    // Counter reload values: each phase lasts (load + 1) cycles.
    localparam logic [3:0] SetupLd    = 4'(SETUP_CYC - 1);
    localparam logic [3:0] StrobeLd   = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HoldLd     = 4'(HOLD_CYC - 1);
    localparam logic [3:0] RecoveryLd = 4'(RECOVERY_CYC - 1);

    state_e     state_q;
    logic [3:0] cnt_q;
    logic       is_write_q;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q         <= StIdle;
            cnt_q           <= 4'd0;
            is_write_q      <= 1'b0;
            oADDR           <= 2'd0;
            oDATA           <= 16'd0;
            oCS_N           <= 1'b1;
            oRD_N           <= 1'b1;
            oWR_N           <= 1'b1;
            avs_readdata    <= 16'd0;
            avs_waitrequest <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (avs_chipselect && (avs_read || avs_write)) begin
                        oADDR      <= avs_address;
                        is_write_q <= avs_write;
                        if (avs_write) begin
                            oDATA <= avs_writedata;
                        end
                        oCS_N   <= 1'b0;
                        cnt_q   <= SetupLd;
                        state_q <= StSetup;
                    end
                end
                StSetup: begin
                    if (cnt_q == 4'd0) begin
                        oWR_N   <= ~is_write_q;
                        oRD_N   <= is_write_q;
                        cnt_q   <= StrobeLd;
                        state_q <= StStrobe;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StStrobe: begin
                    if (cnt_q == 4'd0) begin
                        // Capture on the edge that ends the last strobe cycle.
                        if (!is_write_q) begin
                            avs_readdata <= iDATA;
                        end
                        oRD_N   <= 1'b1;
                        oWR_N   <= 1'b1;
                        cnt_q   <= HoldLd;
                        state_q <= StHold;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StHold: begin
                    if (cnt_q == 4'd0) begin
                        oCS_N           <= 1'b1;
                        avs_waitrequest <= 1'b0;
                        state_q         <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StDone: begin
                    avs_waitrequest <= 1'b1;
                    if (RECOVERY_CYC == 0) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q   <= RecoveryLd;
                        state_q <= StRecover;
                    end
                end
                StRecover: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef ISP1362_BRIDGE_INT_SYNC_EN
    logic [1:0] int0_sync_q;
    logic [1:0] int1_sync_q;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            int0_sync_q <= 2'b11;
            int1_sync_q <= 2'b11;
        end else begin
            int0_sync_q <= {int0_sync_q[0], iINT0_N};
            int1_sync_q <= {int1_sync_q[0], iINT1_N};
        end
    end

    assign avs_irq = ~int0_sync_q[1] | ~int1_sync_q[1];
`else
    // Interrupt inputs are assumed already synchronous to iCLK.
    assign avs_irq = ~iINT0_N | ~iINT1_N;
`endif

endmodule
